// File: rtl/xbar_out_arbiter4.sv
// Per-output round-robin packet arbiter for a 4x4 crossbar: owns the output
// from a packet's first beat to its EOP beat and drives the data mux select.
module xbar_out_arbiter4 #(
  parameter int MAX_STALL = 16,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic [3:0] eop_i,
  input  logic       out_ready_i,
  output logic [3:0] gnt_o,
  output logic       s1_o,
  output logic       s0_o,
  output logic       sel_valid_o,
  output logic       beat_o,
  output logic       timeout_o,
  output logic       dbg_state_o,
  output logic [1:0] dbg_ptr_o
);

  // Handshake: a beat transfers in every cycle where sel_valid_o, req_i[g] and
  // out_ready_i are all high (g = granted input); beat_o reports exactly that.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam bit              WD_EN      = (MAX_STALL > 0);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MAX_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             beat;
  logic             do_arb;
  logic             release_now;
  logic [1:0]       arb_start;
  logic [2:0]       pick;

  // Returns {found, index}: first requester scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign beat = req_i[sel_q] & out_ready_i & (state_q == BUSY);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    timeout_d   = 1'b0;
    stall_d     = stall_q;
    do_arb      = 1'b0;
    release_now = 1'b0;
    arb_start   = ptr_q;

    case (state_q)
      IDLE: do_arb = 1'b1;
      BUSY: begin
        if (beat && eop_i[sel_q]) begin
          release_now = 1'b1;
        end else if (beat) begin
          stall_d = '0;
        end else if (WD_EN && (stall_q == STALL_LAST)) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else if (stall_q != CNT_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: do_arb = 1'b1;
    endcase

    // Release hands priority to the input after g; g itself is scanned last.
    if (release_now) begin
      ptr_d     = sel_q + 2'd1;
      arb_start = sel_q + 2'd1;
      do_arb    = 1'b1;
    end

    pick = rr_pick(req_i, arb_start);

    if (do_arb) begin
      stall_d = '0;
      if (pick[2]) begin
        state_d = BUSY;
        sel_d   = pick[1:0];
        gnt_d   = 4'b0001 << pick[1:0];
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign s1_o        = sel_q[1];
  assign s0_o        = sel_q[0];
  assign sel_valid_o = (state_q == BUSY);
  assign beat_o      = beat;
  assign timeout_o   = timeout_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule
